// File: rtl/fifo_wr_arbiter_1_if.sv
// Write-port bundle between NUM_REQ requesters, the shared FIFO write side and the arbiter.
// The master side drives requests, data and the FIFO full flag; the slave side is the arbiter.
interface fifo_wr_arbiter_1_if #(
  parameter int NUM_REQ      = 4,
  parameter int MEMORY_WIDTH = 8,
  parameter int ID_WIDTH     = 2
);
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*MEMORY_WIDTH-1:0] req_data;
  logic                            w_full;
  logic [NUM_REQ-1:0]              gnt;
  logic [ID_WIDTH-1:0]             grant_id;
  logic                            w_en;
  logic [MEMORY_WIDTH-1:0]         wdata;
  logic                            busy;

  modport master (
    output req, req_data, w_full,
    input  gnt, grant_id, w_en, wdata, busy
  );

  modport slave (
    input  req, req_data, w_full,
    output gnt, grant_id, w_en, wdata, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_1.sv
// Round-robin burst scheduler sharing one FIFO write port among NUM_REQ requesters (w_clk domain).
// Define FIFO_WR_ARB_STATS_EN to add the stall_cnt output and stats_clr input.
module fifo_wr_arbiter_1 #(
  parameter int NUM_REQ      = 4,
  parameter int MEMORY_WIDTH = 8,
  parameter int MAX_BURST    = 4,
  parameter int ID_WIDTH     = 2
) (
  input  logic                     w_clk,
  input  logic                     wrst,
  fifo_wr_arbiter_1_if.slave       bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int unsigned          NREQ_U    = NUM_REQ;
  localparam int                   BEAT_W    = $clog2(MAX_BURST) + 1;
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0]  LAST_REQ  = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]   last_ptr_q, last_ptr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;

  logic                  in_burst;
  logic                  req_sel;
  logic                  accept;
  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_id;
  logic [ID_WIDTH-1:0]   rr_cand;
  logic [MEMORY_WIDTH-1:0] wdata_mux;

  assign in_burst = (state_q == BURST);
  assign req_sel  = bus.req[grant_id_q];
  assign accept   = in_burst & req_sel & ~bus.w_full;

  // Search starts just above the last winner, so the requester just served ranks lowest.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rr_cand   = '0;
    for (int unsigned k = 1; k <= NREQ_U; k++) begin
      rr_cand = ID_WIDTH'((32'(last_ptr_q) + k) % NREQ_U);
      if (!win_found && bus.req[rr_cand]) begin
        win_found = 1'b1;
        win_id    = rr_cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    grant_id_d = grant_id_q;
    last_ptr_d = last_ptr_q;
    beat_d     = beat_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          state_d    = BURST;
          gnt_d      = NUM_REQ'(1) << win_id;
          grant_id_d = win_id;
          last_ptr_d = win_id;
          beat_d     = '0;
        end
      end
      BURST: begin
        if (accept) begin
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
            gnt_d   = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else if (!req_sel) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge w_clk or posedge wrst) begin
    if (wrst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      grant_id_q <= '0;
      last_ptr_q <= LAST_REQ;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      grant_id_q <= grant_id_d;
      last_ptr_q <= last_ptr_d;
      beat_q     <= beat_d;
    end
  end

  // Data is forced to zero outside a burst so idle cycles never show a stale word.
  always_comb begin
    wdata_mux = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (in_burst && (grant_id_q == ID_WIDTH'(i))) begin
        wdata_mux = bus.req_data[i*MEMORY_WIDTH +: MEMORY_WIDTH];
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = in_burst;
  assign bus.w_en     = accept;
  assign bus.wdata    = wdata_mux;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stats_clr) begin
      stall_cnt_d = '0;
    end else if (in_burst && req_sel && bus.w_full && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge w_clk or posedge wrst) begin
    if (wrst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  a_gnt_onehot: assert property (@(posedge w_clk) disable iff (wrst)
    $onehot0(gnt_q));

  a_gnt_matches_state: assert property (@(posedge w_clk) disable iff (wrst)
    in_burst == (gnt_q != '0));

  a_gnt_matches_id: assert property (@(posedge w_clk) disable iff (wrst)
    in_burst |-> gnt_q[grant_id_q]);

  a_no_write_when_full: assert property (@(posedge w_clk) disable iff (wrst)
    bus.w_en |-> !bus.w_full);

  a_beat_in_range: assert property (@(posedge w_clk) disable iff (wrst)
    beat_q <= LAST_BEAT);

endmodule

// File: tb/tb_fifo_wr_arbiter_1.sv
// Scoreboard bench for fifo_wr_arbiter_1: requesters push presented words, a monitor pops on writes.
// Define FIFO_WR_ARB_STATS_EN to also exercise the stall counter.
module tb_fifo_wr_arbiter_1;
  localparam int NUM_REQ   = 4;
  localparam int MW        = 8;
  localparam int MAX_BURST = 4;
  localparam int IDW       = 2;

  logic w_clk = 1'b0;
  logic wrst  = 1'b1;
  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter_1_if #(.NUM_REQ(NUM_REQ), .MEMORY_WIDTH(MW), .ID_WIDTH(IDW)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] stall_cnt;
`endif

  fifo_wr_arbiter_1 #(
    .NUM_REQ(NUM_REQ),
    .MEMORY_WIDTH(MW),
    .MAX_BURST(MAX_BURST),
    .ID_WIDTH(IDW)
  ) dut (
    .w_clk(w_clk),
    .wrst(wrst),
    .bus(bus)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stats_clr(stats_clr),
    .stall_cnt(stall_cnt)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [MW-1:0] exp_q [NUM_REQ][$];
  int            grant_log[$];
  int unsigned   wr_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] cons_s;
  bit            use_fixed = 1'b0;
  logic [MW-1:0] fixed_word = 8'hA5;

  // reference model state: owner=-1 means nobody holds the port
  int            m_owner = -1;
  int            m_beats = 0;
  int            m_last  = NUM_REQ - 1;
  logic [15:0]   m_stall = '0;
  logic [NUM_REQ-1:0] prev_gnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int log_at(input int k);
    return (k < grant_log.size()) ? grant_log[k] : -1;
  endfunction

  // what each requester sees as "my word was taken this cycle"
  always @(negedge w_clk) cons_s = bus.gnt & bus.req & {NUM_REQ{~bus.w_full}};

  always @(negedge w_clk) begin : monitor
    logic [NUM_REQ-1:0] eg;
    logic               ew;
    logic [MW-1:0]      w;
    int                 gi;
    if (wrst) begin
      m_owner  = -1;
      m_beats  = 0;
      m_last   = NUM_REQ - 1;
      m_stall  = '0;
      prev_gnt = '0;
      grant_log.delete();
      for (int i = 0; i < NUM_REQ; i++) wr_cnt[i] = 0;
    end else begin
      eg = (m_owner >= 0) ? NUM_REQ'(1 << m_owner) : '0;
      ew = (m_owner >= 0) && bus.req[m_owner] && !bus.w_full;
      chk("gnt", 32'(bus.gnt), 32'(eg));
      chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
      if (m_owner >= 0) chk("grant_id", 32'(bus.grant_id), 32'(m_owner));
      chk("w_en", 32'(bus.w_en), 32'(ew));
      if (ew) begin
        if (exp_q[m_owner].size() == 0) begin
          chk("scoreboard_word_available", 32'd0, 32'd1);
        end else begin
          w = exp_q[m_owner].pop_front();
          chk("wdata", 32'(bus.wdata), 32'(w));
        end
      end else if (m_owner < 0) begin
        chk("wdata_idle", 32'(bus.wdata), 32'd0);
      end
`ifdef FIFO_WR_ARB_STATS_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      if (stats_clr) m_stall = '0;
      else if ((m_owner >= 0) && bus.req[m_owner] && bus.w_full && (m_stall != 16'hFFFF))
        m_stall = m_stall + 16'd1;
`endif
      // observed grant history and per-requester write counts, taken from the DUT
      gi = -1;
      for (int i = NUM_REQ - 1; i >= 0; i--) if (bus.gnt[i]) gi = i;
      if (bus.gnt != '0 && prev_gnt == '0) grant_log.push_back(gi);
      if (bus.w_en) wr_cnt[bus.grant_id]++;
      prev_gnt = bus.gnt;
      // advance to next cycle by the scheduling rules
      if (m_owner < 0) begin
        if (bus.req != '0) begin
          for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (m_last + k) % NUM_REQ;
            if (m_owner < 0 && bus.req[idx]) m_owner = idx;
          end
          m_last  = m_owner;
          m_beats = 0;
        end
      end else if (ew) begin
        m_beats++;
        if (m_beats == MAX_BURST) m_owner = -1;
      end else if (!bus.req[m_owner]) begin
        m_owner = -1;
      end
    end
  end

  // One requester cycle: drop (withdrawing an untaken word), present a new word, or hold.
  task automatic cycle(input logic [NUM_REQ-1:0] want, input logic full);
    logic [MW-1:0] w;
    @(posedge w_clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req[i] && !want[i]) begin
        if (!cons_s[i] && exp_q[i].size() > 0) void'(exp_q[i].pop_back());
        bus.req[i] = 1'b0;
      end else if (want[i] && (!bus.req[i] || cons_s[i])) begin
        w = use_fixed ? fixed_word : MW'($urandom);
        bus.req_data[i*MW +: MW] = w;
        exp_q[i].push_back(w);
        bus.req[i] = 1'b1;
      end
    end
    bus.w_full = full;
  endtask

  task automatic settle();
    @(negedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge w_clk);
    #1;
    wrst         = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    bus.w_full   = 1'b0;
    use_fixed    = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
    stats_clr    = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) exp_q[i].delete();
    repeat (2) @(posedge w_clk);
    #1;
    wrst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_REQ-1:0] want;
    logic [MW-1:0]      w;
    bus.req      = '0;
    bus.req_data = '0;
    bus.w_full   = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
    stats_clr    = 1'b0;
`endif
    #2;
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    chk("reset_grant_id", 32'(bus.grant_id), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_w_en", 32'(bus.w_en), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // single requester, fixed word: 4-beat burst, one bubble, re-grant
    do_reset();
    use_fixed = 1'b1;
    repeat (6) cycle(4'b0001, 1'b0);
    settle();
    chk("t1_writes_req0", wr_cnt[0], 32'd4);
    chk("t1_bubble_gnt", 32'(bus.gnt), 32'd0);
    cycle(4'b0001, 1'b0);
    settle();
    chk("t1_regrant_count", 32'(grant_log.size()), 32'd2);
    chk("t1_regrant_gnt", 32'(bus.gnt), 32'b0001);
    use_fixed = 1'b0;

    // all requesting: rotation 0,1,2,3,0
    do_reset();
    repeat (22) cycle(4'b1111, 1'b0);
    settle();
    for (int k = 0; k < 5; k++) chk($sformatf("t2_order_%0d", k), 32'(log_at(k)), 32'(k % NUM_REQ));
    for (int i = 1; i < NUM_REQ; i++) chk($sformatf("t2_writes_req%0d", i), wr_cnt[i], 32'd4);

    // full stall mid-burst holds the grant
    do_reset();
    repeat (3) cycle(4'b0100, 1'b0);
    repeat (5) cycle(4'b0100, 1'b1);
    settle();
    chk("t3_gnt_held_in_stall", 32'(bus.gnt), 32'b0100);
    chk("t3_writes_before_release", wr_cnt[2], 32'd2);
    repeat (2) cycle(4'b0100, 1'b0);
    settle();
    chk("t3_writes_req2", wr_cnt[2], 32'd4);
    cycle(4'b0000, 1'b0);
    settle();
    chk("t3_idle_after", 32'(bus.busy), 32'd0);
    chk("t3_grants", 32'(grant_log.size()), 32'd1);

    // requester 1 drops early while 3 waits
    do_reset();
    cycle(4'b0010, 1'b0);
    repeat (2) cycle(4'b1010, 1'b0);
    repeat (3) cycle(4'b1000, 1'b0);
    settle();
    chk("t4_first", 32'(log_at(0)), 32'd1);
    chk("t4_second", 32'(log_at(1)), 32'd3);
    chk("t4_writes_req1", wr_cnt[1], 32'd2);
    repeat (3) cycle(4'b0000, 1'b0);

    // asynchronous reset in the middle of a burst
    do_reset();
    repeat (3) cycle(4'b0001, 1'b0);
    #2;
    chk("t5_pre_reset_gnt", 32'(bus.gnt), 32'b0001);
    wrst = 1'b1;
    #1;
    chk("t5_async_gnt", 32'(bus.gnt), 32'd0);
    chk("t5_async_w_en", 32'(bus.w_en), 32'd0);
    chk("t5_async_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) exp_q[i].delete();
    bus.req = '0;
    for (int i = 1; i <= 2; i++) begin
      w = MW'($urandom);
      bus.req_data[i*MW +: MW] = w;
      exp_q[i].push_back(w);
      bus.req[i] = 1'b1;
    end
    repeat (2) @(posedge w_clk);
    #1;
    wrst = 1'b0;
    repeat (3) cycle(4'b0110, 1'b0);
    settle();
    chk("t5_first_after_reset", 32'(log_at(0)), 32'd1);
    repeat (2) cycle(4'b0000, 1'b0);

`ifdef FIFO_WR_ARB_STATS_EN
    // stall counter and clear-over-increment priority
    do_reset();
    repeat (2) cycle(4'b0001, 1'b0);
    repeat (7) cycle(4'b0001, 1'b1);
    cycle(4'b0001, 1'b1);
    stats_clr = 1'b1;
    settle();
    chk("t6_stall_7", 32'(stall_cnt), 32'd7);
    cycle(4'b0001, 1'b0);
    stats_clr = 1'b0;
    settle();
    chk("t6_stall_cleared", 32'(stall_cnt), 32'd0);
    repeat (3) cycle(4'b0000, 1'b0);
`endif

    // randomized traffic with random full and request toggling
    do_reset();
    want = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_REQ; i++) if ($urandom_range(7) == 0) want[i] = ~want[i];
      cycle(want, ($urandom_range(3) == 0));
`ifdef FIFO_WR_ARB_STATS_EN
      stats_clr = ($urandom_range(31) == 0);
`endif
    end
`ifdef FIFO_WR_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (10) cycle(4'b0000, 1'b0);
    settle();
    for (int i = 0; i < NUM_REQ; i++)
      chk($sformatf("drain_q%0d_empty", i), 32'(exp_q[i].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter_1.md
Name: fifo_wr_arbiter_1

Overview:
- Round-robin write-port scheduler that shares one async FIFO write side among NUM_REQ requesters.
- Sits entirely in the w_clk domain, between the requesters and the FIFO's w_en/wdata/w_full.
- Grants one requester at a time for a bounded burst of up to MAX_BURST words.
- Gates writes against w_full, so no word is dropped or duplicated.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MEMORY_WIDTH, 8, data word width; must match the FIFO.
- MAX_BURST, 4, maximum words accepted per grant (>=1).
- ID_WIDTH, 2, width of grant_id; must equal clog2(NUM_REQ).

Ports:
- w_clk  input  1  write-domain clock, all logic on rising edge.
- wrst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request; bit i is requester i.
- req_data  input  NUM_REQ*MEMORY_WIDTH  packed words; requester i occupies bits [i*MEMORY_WIDTH +: MEMORY_WIDTH].
- w_full  input  1  FIFO full flag, already in the w_clk domain.
- gnt  output  NUM_REQ  one-hot grant (registered).
- grant_id  output  ID_WIDTH  binary index of the granted requester (registered).
- w_en  output  1  FIFO write enable.
- wdata  output  MEMORY_WIDTH  FIFO write data.
- busy  output  1  high while in BURST.

Behaviour:
- Reset (wrst=1, asynchronous):
  - state=IDLE, gnt=0, grant_id=0, busy=0, w_en=0.
  - beat counter=0.
  - last-grant pointer=NUM_REQ-1, so requester 0 wins first.
- Reset mid-burst aborts immediately. A word with w_en high in the same cycle is not guaranteed written; requesters must retry.
- Accept condition: accept = busy & req[grant_id] & !w_full.
  - w_en = accept (combinational from registered state and live inputs).
  - wdata = req_data slice[grant_id] (combinational mux); it is 0 when busy=0.
- IDLE:
  - gnt=0, busy=0.
  - If req != 0, pick the first set bit searching upward from last_ptr+1, wrapping modulo NUM_REQ.
  - Register gnt/grant_id, set last_ptr to the winner, clear beat counter, go to BURST.
  - Latency is 1 cycle from req rising in IDLE to gnt high.
  - If req == 0, stay in IDLE.
- BURST:
  - On accept, beat counter increments.
  - Exit to IDLE when either:
    - req[grant_id]==0 (no accept that cycle), or
    - accept occurs with beat counter == MAX_BURST-1.
  - gnt clears on the following edge.
- w_full in BURST: no accept and no count change; the grant holds indefinitely.
- There is always exactly one IDLE bubble cycle between consecutive bursts, including when the same requester re-wins.
- Requester handshake:
  - A word is consumed in every cycle where gnt[i] & req[i] & !w_full.
  - The requester must present the next word, or drop req, after each consumed cycle.
  - Requests from non-granted requesters are ignored and held off; no implicit queueing.
- Fairness: the requester just served has lowest priority at the next arbitration. With all requesters requesting, the grant order is 0,1,2,3,0,...
- Beat counter width is clog2(MAX_BURST)+1 and never exceeds MAX_BURST-1 at the decision point.
- Simultaneous events:
  - req drop and w_full together → exit to IDLE, no write.
  - Final beat accepted while another requester asserts req → that requester is arbitrated in the following IDLE cycle.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0], reset to 0.
  - Increments by 1 each cycle with busy & req[grant_id] & w_full.
  - Saturates at 16'hFFFF.
  - Adds input stats_clr (1 bit); synchronous clear that has priority over increment.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Reset, then req=4'b0001 held with req_data[0]=8'hA5, w_full=0 → gnt=0001 one cycle later. w_en high for exactly 4 cycles with wdata=A5, then one gnt=0 cycle, then gnt=0001 again.
- req=4'b1111 held, w_full=0 → burst order 0,1,2,3,0. Each burst is 4 w_en cycles, each followed by 1 idle cycle; grant_id sequence is 0,1,2,3,0.
- Requester 2 alone, w_full asserted after 2 accepts for 5 cycles → w_en low for those 5 cycles, gnt=0100 held, 2 further accepts after w_full drops, then IDLE.
- Requester 1 drops req after 2 accepts while req[3]=1 → IDLE for 1 cycle, then gnt=1000. Requester 1 saw exactly 2 writes.
- wrst pulsed mid-burst (after 1 accept) → gnt, w_en, busy are 0 asynchronously. After release with req=4'b0110, the first grant goes to requester 1.
- With FIFO_WR_ARB_STATS_EN: 7 full-stall cycles → stall_cnt=7. Then stats_clr=1 for 1 cycle → 0.
